// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: hold, +4 advance (wrapping), aligned redirect load.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc_reg;

    // Load wins over increment so a redirect always lands on its target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (load) begin
            pc_reg <= load_pc & ALIGN_MASK;
        end else if (inc) begin
            pc_reg <= pc_reg + STEP;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word read, valid/ready to decode,
// branch redirect with cancellation of any stale in-flight response.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e      state_reg, state_next;
    logic              pc_inc, pc_load, capture;
    logic [ADDR_W-1:0] fetch_pc;
    logic [31:0]       instr_reg;
    logic [ADDR_W-1:0] pc_reg, pc_plus4_reg;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_pc (redirect_pc_i),
        .pc      (fetch_pc)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Redirect dominates every non-IDLE state; a response granted before or
    // alongside a redirect is routed through DROP so it can never be shown.
    always_comb begin
        state_next = state_reg;
        pc_inc     = 1'b0;
        capture    = 1'b0;
        pc_load    = redirect_i && (state_reg != IDLE);
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_gnt_i) begin
                    state_next = redirect_i ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_next = redirect_i ? REQ : HOLD;
                    capture    = !redirect_i;
                    pc_inc     = !redirect_i;
                end else if (redirect_i) begin
                    state_next = DROP;
                end
            end
            HOLD: begin
                if (redirect_i || instr_ready_i) begin
                    state_next = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_reg    <= '0;
            pc_reg       <= '0;
            pc_plus4_reg <= STEP;
        end else if (capture) begin
            instr_reg    <= imem_rdata_i;
            pc_reg       <= fetch_pc;
            pc_plus4_reg <= fetch_pc + STEP;
        end
    end

    assign imem_req_o    = (state_reg == REQ);
    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = (state_reg == HOLD);
    assign instr_o       = instr_reg;
    assign pc_o          = pc_reg;
    assign pc_plus4_o    = pc_plus4_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: reactive memory plus a transaction-level fetch model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: what decode should see and where the next fetch goes.
    bit          m_idle, m_valid, m_out, m_stale;
    logic [31:0] m_instr, m_pc, m_pc4, m_next, m_out_addr;
    // Memory side
    bit          mem_pending;
    logic [31:0] mem_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit exp_req();
        return !m_idle && !m_valid && !m_out;
    endfunction

    task automatic model_reset();
        m_idle  = 1'b1;
        m_valid = 1'b0;
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_instr = '0;
        m_pc    = '0;
        m_pc4   = 32'd4;
        m_next  = RST_PC;
    endtask

    task automatic check_outputs();
        chk("valid", {31'b0, instr_valid_o}, {31'b0, m_valid});
        chk("req", {31'b0, imem_req_o}, {31'b0, exp_req()});
        if (exp_req()) chk("addr", imem_addr_o, m_next);
        if (m_valid) begin
            chk("instr", instr_o, m_instr);
            chk("pc", pc_o, m_pc);
            chk("pc4", pc_plus4_o, m_pc4);
        end
    endtask

    // One clock: drive at the falling edge, update model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input bit g, input bit rv, input bit rdy, input bit rd,
                         input logic [31:0] tgt);
        bit          gd, rvd, req_model;
        logic [31:0] addr_pre, data;
        rvd      = rv && mem_pending;
        gd       = g && imem_req_o && !rvd;
        addr_pre = imem_addr_o;
        data     = rvd ? mem_word(mem_addr) : $urandom;
        imem_gnt_i    = gd;
        imem_rvalid_i = rvd;
        imem_rdata_i  = data;
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        req_model     = exp_req();
        @(posedge clk);
        if (rvd) mem_pending = 1'b0;
        if (gd) begin
            mem_pending = 1'b1;
            mem_addr    = addr_pre;
        end
        if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            if (m_valid && (rdy || rd)) begin
                if (!rd) $display("xfer pc=%h instr=%h", m_pc, m_instr);
                m_valid = 1'b0;
            end
            if (req_model && gd) begin
                m_out      = 1'b1;
                m_out_addr = m_next;
                m_stale    = rd;
            end else if (m_out && rvd) begin
                m_out = 1'b0;
                if (!m_stale && !rd) begin
                    m_valid = 1'b1;
                    m_instr = data;
                    m_pc    = m_out_addr;
                    m_pc4   = m_out_addr + 32'd4;
                    m_next  = m_out_addr + 32'd4;
                end
            end else if (m_out && rd) begin
                m_stale = 1'b1;
            end
            if (rd) m_next = {tgt[31:2], 2'b00};
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset asserted between clock edges; optionally keep the
    // in-flight memory response so it arrives late after release.
    task automatic do_reset(input bit keep_late);
        rst_i = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, RST_PC);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_pc4", pc_plus4_o, 32'd4);
        model_reset();
        if (!keep_late) mem_pending = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] tgt;
        mem_pending = 1'b0;
        mem_addr    = '0;
        m_out_addr  = '0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);

        // First fetch with a zero-wait memory.
        repeat (3) cycle(1, 1, 1, 0, 0);
        chk("t1_instr", instr_o, 32'h2008_0005);
        chk("t1_pc", pc_o, 32'h0);
        chk("t1_pc4", pc_plus4_o, 32'h4);
        cycle(1, 1, 1, 0, 0);
        chk("t1_next_addr", imem_addr_o, 32'h4);

        // Decode stalls for five cycles in HOLD.
        repeat (2) cycle(1, 1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 0);
        chk("t2_pc", pc_o, 32'h4);
        cycle(0, 0, 1, 0, 0);
        chk("t2_next_addr", imem_addr_o, 32'h8);

        // Redirect during WAIT, stale response discarded.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h0000_0043);
        cycle(0, 1, 0, 0, 0);
        chk("t3_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("t3_addr", imem_addr_o, 32'h40);

        // Redirect with grant, then redirect with rvalid.
        cycle(1, 0, 0, 1, 32'h0000_0100);
        cycle(0, 1, 0, 0, 0);
        chk("t4a_addr", imem_addr_o, 32'h100);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 32'h0000_0200);
        chk("t4b_req", {31'b0, imem_req_o}, 32'd1);
        chk("t4b_addr", imem_addr_o, 32'h200);

        // Address wrap at the top of memory.
        cycle(0, 0, 0, 1, 32'hFFFF_FFFF);
        chk("t5_addr", imem_addr_o, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        chk("t5_pc4", pc_plus4_o, 32'h0);
        cycle(0, 0, 1, 0, 0);
        chk("t5_next_addr", imem_addr_o, 32'h0);

        // Reset while a read is in flight, late response after release.
        cycle(1, 0, 1, 0, 0);
        do_reset(1'b1);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        chk("t6_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("t6_addr", imem_addr_o, RST_PC);

        // Randomized traffic with occasional redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFFF;
                1:       tgt = 32'hFFFF_FFF6;
                default: tgt = $urandom;
            endcase
            if ((i % 600) == 599) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, tgt);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the control decoder. It holds the fetch PC and issues one word read at a time to instruction memory over a request/grant/response handshake. It presents the returned instruction to decode through a valid/ready handshake. It applies branch redirects from execute (Branch & Zero) and discards any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
ADDR_W, 32, PC / memory address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
imem_req_o  out  1  read request to instruction memory
imem_addr_o  out  ADDR_W  word-aligned read address
imem_gnt_i  in  1  memory accepted request this cycle
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  32  read data
instr_valid_o  out  1  instr_o/pc_o valid to decode
instr_ready_i  in  1  decode accepts instruction this cycle
instr_o  out  32  instruction word (opcode = instr_o[31:26])
pc_o  out  ADDR_W  address of instr_o
pc_plus4_o  out  ADDR_W  pc_o + 4, for branch-target adder
redirect_i  in  1  taken branch; refetch from redirect_pc_i
redirect_pc_i  in  ADDR_W  branch target

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, fetch_pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=4.
- States: IDLE, REQ, WAIT, HOLD, DROP. At most one memory transaction is outstanding.
- IDLE: entered only from reset. Moves to REQ on the first clock edge after reset release.
- REQ: imem_req_o=1 and imem_addr_o=fetch_pc, held stable until imem_gnt_i=1. On grant -> WAIT.
- WAIT: imem_req_o=0. On imem_rvalid_i: instr_o<=imem_rdata_i, pc_o<=fetch_pc, pc_plus4_o<=fetch_pc+4, fetch_pc<=fetch_pc+4, -> HOLD.
- HOLD: instr_valid_o=1. Outputs stay stable until instr_ready_i=1, then -> REQ. instr_valid_o drops the next cycle.
- DROP: waits for the response of a cancelled transaction. On imem_rvalid_i the data is discarded -> REQ.
- Latency: REQ to HOLD is at least 2 cycles with a zero-wait memory (grant in the first REQ cycle, rvalid in the next cycle). Throughput is one instruction per 3 cycles at best.
- imem_rvalid_i never coincides with the grant cycle. imem_rvalid_i is ignored in IDLE, REQ and HOLD.
- Redirect (highest priority, any state except IDLE): fetch_pc<=redirect_pc_i with bits [1:0] forced to 00.
  - In REQ without grant -> stays REQ; the new address appears next cycle.
  - In REQ with grant in the same cycle -> DROP.
  - In WAIT without rvalid -> DROP.
  - In WAIT with rvalid in the same cycle -> data discarded, -> REQ.
  - In DROP -> stays DROP; with rvalid in the same cycle -> REQ.
  - In HOLD (with or without instr_ready_i) -> instr_valid_o<=0, -> REQ.
- Redirect in IDLE is ignored.
- Arithmetic is modulo 2^ADDR_W: fetch_pc=32'hFFFF_FFFC advances to 0. pc_plus4_o wraps the same way.
- Reset asserted mid-transaction: immediate return to reset values. A late memory response after reset release arrives in IDLE/REQ and is ignored.

Decomposition:
- fetch_pkg holds:
  - the state enum (IDLE, REQ, WAIT, HOLD, DROP)
  - the PC_STEP=4 constant
  - the default RESET_PC constant
- One sub-module, fetch_pc_reg: owns the fetch_pc register. It provides hold, increment (+4, wrapping), redirect load with alignment masking, and asynchronous reset to RESET_PC.
- The FSM and output register stay in instr_fetch_unit.

Test Plan:
- Reset release, memory grants immediately, rvalid one cycle later with 32'h2008_0005, instr_ready_i=1 -> imem_addr_o=0, then instr_valid_o=1, instr_o=32'h2008_0005, pc_o=0, pc_plus4_o=4. The next request uses address 4.
- instr_ready_i held low 5 cycles in HOLD -> instr_o/pc_o stable, imem_req_o=0 throughout. Fetch of address 8 starts the cycle after ready rises.
- redirect_i=1, redirect_pc_i=32'h0000_0043 during WAIT -> DROP. The stale rvalid data is discarded and never shown with instr_valid_o. The next request is at address 32'h0000_0040.
- Redirect in the same cycle as grant, and separately in the same cycle as rvalid -> first case goes to DROP, second case goes straight to REQ. Both next requests use the redirect address; no stale instruction is presented.
- fetch_pc forced to 32'hFFFF_FFFC via redirect -> pc_plus4_o=0 and the following request address is 0.
- rst_i asserted while in WAIT, then released, with a late imem_rvalid_i two cycles later -> outputs at reset values, late data ignored, first request at RESET_PC.
